// File: rtl/levinson_update_if.sv
// rtl/levinson_update_if.sv - control, coefficient-port and status bundle for levinson_update
//
// Signals (direction as seen by the slave / design side):
//   start   in   request one order-update step
//   k       in   reflection coefficient, Q(FRAC), sampled with start
//   m       in   new predictor order, sampled with start
//   wr_en   in   coefficient preload strobe (honoured only when idle)
//   wr_addr in   preload index, 1..N_MAX
//   wr_data in   preload value
//   rd_addr in   readback index
//   rd_data out  combinational readback of a[rd_addr], 0 outside 1..N_MAX
//   busy    out  step in progress
//   done    out  one-cycle completion pulse
//   sat     out  a clamp occurred during the last step
//   err     out  last start carried an out-of-range order
interface levinson_update_if #(
    parameter int W     = 32,
    parameter int N_MAX = 16
) ();
    localparam int AW = $clog2(N_MAX + 1);

    logic                 start;
    logic signed [W-1:0]  k;
    logic [AW-1:0]        m;
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic signed [W-1:0]  wr_data;
    logic [AW-1:0]        rd_addr;
    logic signed [W-1:0]  rd_data;
    logic                 busy;
    logic                 done;
    logic                 sat;
    logic                 err;

    modport master (
        output start, k, m, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, sat, err
    );

    modport slave (
        input  start, k, m, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, sat, err
    );
endinterface

// File: rtl/levinson_update.sv
// rtl/levinson_update.sv - Levinson-Durbin predictor order-update engine
//
// Holds coefficients a[1..N_MAX]. One step of order m rewrites a[1..m-1]
// in symmetric pairs (i, m-i), each pair in a single cycle from pre-step
// values, then writes a[m] = trz(k, K_SHIFT).
//
// Ports:
//   clk  in  clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  levinson_update_if.slave: start/k/m request, wr_* preload,
//        rd_addr/rd_data readback, busy/done/sat/err status
module levinson_update #(
    parameter int W       = 32,
    parameter int N_MAX   = 16,
    parameter int FRAC    = 15,
    parameter int K_SHIFT = 3
) (
    input  logic             clk,
    input  logic             rst,
    levinson_update_if.slave bus
);
    localparam int AW = $clog2(N_MAX + 1);

    localparam logic signed [W:0]     L_MAX   = {2'b00, {(W-1){1'b1}}};
    localparam logic signed [W:0]     L_MIN   = {2'b11, {(W-1){1'b0}}};
    // Adding 2^s-1 before an arithmetic shift makes negatives round toward zero.
    localparam logic signed [2*W-1:0] L_PBIAS = {{(2*W-FRAC){1'b0}}, {FRAC{1'b1}}};
    localparam logic signed [W-1:0]   L_KBIAS = {{(W-K_SHIFT){1'b0}}, {K_SHIFT{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAIR,
        S_LAST,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic signed [W-1:0] r_a [0:N_MAX];
    logic signed [W-1:0] r_k;
    logic [AW-1:0]       r_m;
    logic [AW-1:0]       r_i;
    logic                r_done;
    logic                r_sat;
    logic                r_err;

    logic                w_accept;
    logic                w_do_pair;
    logic                w_do_last;
    logic                w_pre_wr;
    logic                w_m_ok;
    logic                w_wr_ok;
    logic                w_rd_ok;

    logic [AW-1:0]         w_j;
    logic signed [W-1:0]   w_ai;
    logic signed [W-1:0]   w_aj;
    logic signed [2*W-1:0] w_k_ext;
    logic signed [2*W-1:0] w_ai_ext;
    logic signed [2*W-1:0] w_aj_ext;
    logic signed [2*W-1:0] w_prod_i;
    logic signed [2*W-1:0] w_prod_j;
    logic signed [W:0]     w_sum_i;
    logic signed [W:0]     w_sum_j;
    logic [W:0]            w_sat_i;
    logic [W:0]            w_sat_j;
    logic signed [W-1:0]   w_k_top;

    // trz(p, FRAC), kept to W+1 bits for the widened sum.
    function automatic logic signed [W:0] f_trz_prod(input logic signed [2*W-1:0] p);
        logic signed [2*W-1:0] t;
        t = p;
        if (p[2*W-1]) begin
            t = p + L_PBIAS;
        end
        t = t >>> FRAC;
        return t[W:0];
    endfunction

    // Returns {clamped, value}.
    function automatic logic [W:0] f_sat(input logic signed [W:0] s);
        if (s > L_MAX) begin
            return {1'b1, L_MAX[W-1:0]};
        end else if (s < L_MIN) begin
            return {1'b1, L_MIN[W-1:0]};
        end else begin
            return {1'b0, s[W-1:0]};
        end
    endfunction

    assign w_m_ok  = (bus.m != '0) && (bus.m <= AW'(N_MAX));
    assign w_wr_ok = (bus.wr_addr != '0) && (bus.wr_addr <= AW'(N_MAX));
    assign w_rd_ok = (bus.rd_addr != '0) && (bus.rd_addr <= AW'(N_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_do_pair = 1'b0;
        w_do_last = 1'b0;
        w_pre_wr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    if (!w_m_ok) begin
                        w_next = S_DONE;
                    end else if (bus.m == AW'(1)) begin
                        w_next = S_LAST;
                    end else begin
                        w_next = S_PAIR;
                    end
                end else if (bus.wr_en && w_wr_ok) begin
                    w_pre_wr = 1'b1;
                end
            end
            S_PAIR: begin
                w_do_pair = 1'b1;
                if (r_i == (r_m >> 1)) begin
                    w_next = S_LAST;
                end
            end
            S_LAST: begin
                w_do_last = 1'b1;
                w_next    = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Pair datapath: both halves read the array before either is written.
    assign w_j      = r_m - r_i;
    assign w_ai     = r_a[r_i];
    assign w_aj     = r_a[w_j];
    assign w_k_ext  = {{W{r_k[W-1]}}, r_k};
    assign w_ai_ext = {{W{w_ai[W-1]}}, w_ai};
    assign w_aj_ext = {{W{w_aj[W-1]}}, w_aj};
    assign w_prod_i = w_k_ext * w_aj_ext;
    assign w_prod_j = w_k_ext * w_ai_ext;
    assign w_sum_i  = {w_ai[W-1], w_ai} + f_trz_prod(w_prod_i);
    assign w_sum_j  = {w_aj[W-1], w_aj} + f_trz_prod(w_prod_j);
    assign w_sat_i  = f_sat(w_sum_i);
    assign w_sat_j  = f_sat(w_sum_j);
    assign w_k_top  = (r_k[W-1] ? (r_k + L_KBIAS) : r_k) >>> K_SHIFT;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n <= N_MAX; n++) begin
                r_a[n] <= '0;
            end
            r_k    <= '0;
            r_m    <= '0;
            r_i    <= '0;
            r_done <= 1'b0;
            r_sat  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            // done is the registered image of the DONE state.
            r_done <= (r_state == S_DONE);
            if (w_accept) begin
                r_k   <= bus.k;
                r_m   <= bus.m;
                r_i   <= AW'(1);
                r_sat <= 1'b0;
                r_err <= !w_m_ok;
            end
            if (w_pre_wr) begin
                r_a[bus.wr_addr] <= bus.wr_data;
            end
            if (w_do_pair) begin
                r_a[r_i] <= w_sat_i[W-1:0];
                // Middle element of an even order is its own partner.
                if (w_j != r_i) begin
                    r_a[w_j] <= w_sat_j[W-1:0];
                end
                r_i <= r_i + AW'(1);
                if (w_sat_i[W] || w_sat_j[W]) begin
                    r_sat <= 1'b1;
                end
            end
            if (w_do_last) begin
                r_a[r_m] <= w_k_top;
            end
        end
    end

    assign bus.rd_data = w_rd_ok ? r_a[bus.rd_addr] : '0;
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.done    = r_done;
    assign bus.sat     = r_sat;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_levinson_update.sv
// tb/tb_levinson_update.sv - scoreboard bench for levinson_update
module tb_levinson_update;
    localparam int W  = 32;
    localparam int NM = 16;
    localparam int AW = $clog2(NM + 1);
    localparam longint L_MAX = 64'sd2147483647;
    localparam longint L_MIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    always #50 clk = ~clk;

    levinson_update_if #(.W(W), .N_MAX(NM)) bus ();

    levinson_update #(.W(W), .N_MAX(NM), .FRAC(15), .K_SHIFT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string  tag;
        int     addr;
        longint val;
    } exp_t;

    exp_t   sb[$];
    longint mdl [0:NM];
    int     n_checks = 0;
    int     n_errors = 0;
    int     exp_lat;
    longint exp_sat;
    longint exp_err;

    task automatic check(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int addr, output longint v);
        bus.rd_addr = AW'(addr);
        #1;
        v = longint'(bus.rd_data);
    endtask

    function automatic longint trz(input longint x, input int s);
        return x / (longint'(1) << s);
    endfunction

    task automatic wr_coef(input int addr, input longint d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = AW'(addr);
        bus.wr_data = W'(d);
        tick();
        bus.wr_en = 1'b0;
        if (addr >= 1 && addr <= NM) mdl[addr] = d;
    endtask

    // Reference step: every new a[i] computed from a snapshot of the old array.
    task automatic model_step(input string tag, input longint k, input int m);
        longint old [0:NM];
        longint s;
        old     = mdl;
        exp_sat = 0;
        if (m == 0 || m > NM) begin
            exp_err = 1;
            exp_lat = 1;
        end else begin
            exp_err = 0;
            exp_lat = m / 2 + 2;
            for (int i = 1; i < m; i++) begin
                s = old[i] + trz(k * old[m-i], 15);
                if (s > L_MAX) begin s = L_MAX; exp_sat = 1; end
                if (s < L_MIN) begin s = L_MIN; exp_sat = 1; end
                mdl[i] = s;
            end
            mdl[m] = trz(k, 3);
        end
        for (int i = 1; i <= NM; i++) begin
            sb.push_back('{tag: $sformatf("%s_a%0d", tag, i), addr: i, val: mdl[i]});
        end
    endtask

    task automatic run_step(input string tag, input longint k, input int m,
                            input bit disturb, input bit wr_on_start);
        int     cnt;
        bit     got;
        longint v;
        exp_t   e;
        model_step(tag, k, m);
        bus.k     = W'(k);
        bus.m     = AW'(m);
        bus.start = 1'b1;
        if (wr_on_start) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(5);
            bus.wr_data = 999;
        end
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        check({tag, "_busy"}, longint'(bus.busy), 1);
        if (disturb) begin
            bus.start   = 1'b1;
            bus.k       = 12345;
            bus.m       = AW'(3);
            bus.wr_en   = 1'b1;
            bus.wr_addr = AW'(1);
            bus.wr_data = 77;
        end
        cnt = 0;
        got = 0;
        while (cnt < 40 && !got) begin
            tick();
            cnt++;
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            if (bus.done) got = 1;
        end
        check({tag, "_latency"}, got ? longint'(cnt) : -1, longint'(exp_lat));
        check({tag, "_sat"}, longint'(bus.sat), exp_sat);
        check({tag, "_err"}, longint'(bus.err), exp_err);
        tick();
        check({tag, "_done_width"}, longint'(bus.done), 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            rd(e.addr, v);
            check(e.tag, v, e.val);
        end
    endtask

    initial begin
        longint v;
        int     n_done;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.k       = '0;
        bus.m       = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
        for (int i = 0; i <= NM; i++) mdl[i] = 0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_sat", longint'(bus.sat), 0);
        check("rst_err", longint'(bus.err), 0);
        for (int i = 1; i <= NM; i++) begin
            rd(i, v);
            check($sformatf("rst_a%0d", i), v, 0);
        end

        wr_coef(0, 5);
        wr_coef(17, 6);
        rd(0, v);
        check("rd_addr0", v, 0);
        rd(17, v);
        check("rd_addr17", v, 0);

        wr_coef(1, 1000);
        run_step("t_half", 16384, 2, 0, 0);
        rd(1, v);
        check("t_half_a1_const", v, 1500);
        rd(2, v);
        check("t_half_a2_const", v, 2048);

        wr_coef(1, 3);
        run_step("t_neg", -16384, 2, 0, 0);
        rd(1, v);
        check("t_neg_a1_const", v, 2);
        run_step("t_m1", -9, 1, 0, 0);
        rd(1, v);
        check("t_m1_a1_const", v, -1);

        wr_coef(1, 2147483000);
        wr_coef(2, 65536);
        run_step("t_sat", 32768, 3, 0, 0);
        rd(3, v);
        check("t_sat_a3_const", v, 4096);

        wr_coef(1, 10);
        wr_coef(2, 20);
        wr_coef(3, 30);
        wr_coef(4, 40);
        run_step("t_old", 32768, 4, 0, 0);

        run_step("t_m0", 7, 0, 0, 1);
        run_step("t_m17", 7, 17, 0, 0);

        for (int i = 1; i <= 8; i++) wr_coef(i, i * 1000 - 4500);
        run_step("t_busy", -20000, 8, 1, 0);
        run_step("t_m16", 5000, 16, 0, 0);

        for (int i = 1; i <= 8; i++) wr_coef(i, i * 111);
        bus.k     = 1000;
        bus.m     = AW'(8);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        n_done = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.done) n_done++;
        end
        check("abort_no_done", longint'(n_done), 0);
        for (int i = 0; i <= NM; i++) mdl[i] = 0;
        for (int i = 1; i <= NM; i++) begin
            rd(i, v);
            check($sformatf("abort_a%0d", i), v, mdl[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/levinson_update.md
LEVINSON_UPDATE -- requirements
Module: levinson_update

Interface
REQ-001 SHALL have parameter W, default 32: coefficient and reflection-coefficient word width in bits.
REQ-002 SHALL have parameter N_MAX, default 16: maximum predictor order and number of stored coefficients a[1..N_MAX].
REQ-003 SHALL have parameter FRAC, default 15: fractional bits of k, used to rescale the k*a product.
REQ-004 SHALL have parameter K_SHIFT, default 3: right shift applied to k to form the new highest-order coefficient.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: request one order-update step.
REQ-008 SHALL have port k, input, signed W bits: reflection coefficient, Q(FRAC), sampled with start.
REQ-009 SHALL have port m, input, $clog2(N_MAX+1) bits: new order, sampled with start.
REQ-010 SHALL have ports wr_en (input, 1), wr_addr (input, $clog2(N_MAX+1)) and wr_data (input, signed W): coefficient preload.
REQ-011 SHALL have ports rd_addr (input, $clog2(N_MAX+1)) and rd_data (output, signed W): combinational coefficient readback.
REQ-012 SHALL have ports busy, done, sat and err, each output, 1 bit: status.

Function
REQ-013 Arithmetic SHALL use trz(x,s), an arithmetic right shift of x by s that truncates toward zero (trz(-9,3) = -1, trz(-8,3) = -1, trz(-1,3) = 0).
REQ-014 Update step for order m SHALL compute, for i = 1..m-1, a'[i] = sat_W(a[i] + trz(k*a[m-i], FRAC)), where k*a is an exact 2W-bit product and the sum is formed at W+1 bits; it SHALL then set a'[m] = trz(k, K_SHIFT).
REQ-015 sat_W SHALL clamp to [-2^(W-1), 2^(W-1)-1]; any clamp during a step SHALL set sat, which holds until the next accepted start.
REQ-016 All right-hand-side operands SHALL be old values: i and m-i SHALL be updated together in one cycle from pre-step contents.
REQ-017 The FSM SHALL have states IDLE, PAIR, LAST and DONE.
REQ-018 IDLE: start=1 SHALL latch k and m, clear sat and err, and go to PAIR with i=1 (or to LAST if m=1).
REQ-019 PAIR: each cycle SHALL update pair (i, m-i) (a single write when i = m-i) and increment i; after i = floor(m/2), the FSM SHALL go to LAST.
REQ-020 LAST SHALL write a[m] and go to DONE; DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 busy SHALL be 1 in PAIR, LAST and DONE and 0 in IDLE; done SHALL occur floor(m/2)+2 cycles after the start edge.
REQ-022 If m=0 or m>N_MAX, the start SHALL be accepted, err set, no coefficient written, and the FSM SHALL go directly to DONE.
REQ-023 start while busy=1 SHALL be ignored.
REQ-024 wr_en SHALL write a[wr_addr] only when in IDLE without start; it SHALL be ignored when busy, on the start edge, or when wr_addr=0 or wr_addr>N_MAX.
REQ-025 rd_data SHALL equal a[rd_addr], and 0 for rd_addr=0 or rd_addr>N_MAX; mid-step reads SHALL return current partially updated contents.
REQ-026 Coefficients a[m+1..N_MAX] SHALL be unchanged by a step.

Reset
REQ-027 rst=1 SHALL on the clock edge force IDLE, clear all a[1..N_MAX] to 0, and drive busy=0, done=0, sat=0 and err=0.
REQ-028 rst SHALL take priority over start and wr_en, and SHALL abort a step in progress with no completion pulse.

Verification
REQ-029 Preload a[1]=1000, start with k=16384 and m=2 -> done 3 cycles after start; a[1]=1500, a[2]=2048, sat=0.
REQ-030 Preload a[1]=3, start with k=-16384 and m=2 -> a[1]=2 (trz(-49152,15) = -1), a[2]=-2048; start with k=-9 and m=1 -> a[1]=-1, done 2 cycles after start.
REQ-031 Preload a[1]=2147483000 and a[2]=65536, start with k=32768 and m=3 -> a[1]=2147483647, a[2]=2147483647, a[3]=4096, sat=1, done 3 cycles after start.
REQ-032 Preload a[1..4]=10,20,30,40, start with k=32768 and m=4 -> a[1]=40, a[2]=40, a[3]=40, a[4]=4096 (old-value rule), and a[5..16] unchanged.
REQ-033 Start with m=0, then with m=17 -> err=1, no writes, done 1 cycle after start; start asserted while busy and wr_en asserted while busy -> no effect.
REQ-034 Assert rst during PAIR of an m=8 step -> next cycle busy=0, done=0 and no done pulse follows; all rd_data values are 0.
